// File: rtl/mini_src_pkg.sv
// Shared constants and state encoding for the multiply/divide unit.
package mini_src_pkg;

  localparam int unsigned MDU_WIDTH = 32;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_addsub.sv
// Shared add/subtract datapath used by both the Booth step and the restoring step.
module mdu_addsub #(
  parameter int unsigned W = 33
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_c
);

  // Single adder; subtraction selected by sub_i.
  always_comb begin
    sum_c = sub_i ? (x_i - y_i) : (x_i + y_i);
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative signed multiply (radix-2 Booth) / signed divide (restoring on magnitudes).
module mul_div_unit
  import mini_src_pkg::*;
#(
  parameter int unsigned WIDTH = MDU_WIDTH
) (
  input  logic               clk,
  input  logic               clr_n,
  input  logic               start,
  input  logic               op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div_by_zero
);

  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  mdu_state_e state_q, state_d;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               a_neg_q, a_neg_d;
  logic               b_neg_q, b_neg_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic [WIDTH-1:0]   m_q, m_d;       // mul: multiplicand; div: divisor magnitude
  logic [AW-1:0]      acc_q, acc_d;   // mul: upper partial product; div: partial remainder
  logic [WIDTH-1:0]   lo_q, lo_d;     // mul: multiplier / low product; div: dividend / quotient
  logic               qm1_q, qm1_d;   // Booth q(-1) bit
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   a_mag_c, b_mag_c;
  logic [AW-1:0]      shifted_c;
  logic [AW-1:0]      as_x_c, as_y_c, as_sum_c;
  logic               as_sub_c;
  logic [WIDTH-1:0]   quo_c, rem_c;

  mdu_addsub #(.W(AW)) u_addsub (
    .x_i   (as_x_c),
    .y_i   (as_y_c),
    .sub_i (as_sub_c),
    .sum_c (as_sum_c)
  );

  // Operand magnitudes, divide shift and adder operand selection.
  always_comb begin
    a_mag_c   = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    b_mag_c   = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;
    shifted_c = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
    if (op_q == OP_MUL) begin
      as_x_c   = acc_q;
      as_y_c   = (lo_q[0] ^ qm1_q) ? {m_q[WIDTH-1], m_q} : '0;
      as_sub_c = lo_q[0] & ~qm1_q;
    end else begin
      as_x_c   = shifted_c;
      as_y_c   = {1'b0, m_q};
      as_sub_c = 1'b1;
    end
    quo_c = (a_neg_q ^ b_neg_q) ? (~lo_q + WIDTH'(1)) : lo_q;
    rem_c = a_neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state, datapath update and registered output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_neg_d  = a_neg_q;
    b_neg_d  = b_neg_q;
    a_raw_d  = a_raw_q;
    m_d      = m_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          op_d    = op;
          a_neg_d = a[WIDTH-1];
          b_neg_d = b[WIDTH-1];
          a_raw_d = a;
          acc_d   = '0;
          qm1_d   = 1'b0;
          if (op == OP_MUL) begin
            m_d  = a;
            lo_d = b;
          end else begin
            m_d  = b_mag_c;
            lo_d = a_mag_c;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CW'(1);
        if (op_q == OP_MUL) begin
          acc_d = {as_sum_c[AW-1], as_sum_c[AW-1:1]};
          lo_d  = {as_sum_c[0], lo_q[WIDTH-1:1]};
          qm1_d = lo_q[0];
        end else if (!as_sum_c[AW-1]) begin
          acc_d = as_sum_c;
          lo_d  = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted_c;
          lo_d  = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        if (op_q == OP_MUL) begin
          result_d = {acc_q[WIDTH-1:0], lo_q};
          dbz_d    = 1'b0;
        end else if (m_q == '0) begin
          result_d = {a_raw_q, {WIDTH{1'b1}}};
          dbz_d    = 1'b1;
        end else begin
          result_d = {rem_c, quo_c};
          dbz_d    = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      a_raw_q  <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_neg_q  <= a_neg_d;
      b_neg_q  <= b_neg_d;
      a_raw_q  <= a_raw_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign result      = result_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, monitor compares on done.
module tb_mul_div_unit;
  import mini_src_pkg::*;

  localparam int unsigned W = 32;

  logic           clk;
  logic           clr_n;
  logic           start;
  logic           op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           div_by_zero;

  typedef struct packed {
    logic [63:0] res;
    logic        dbz;
  } exp_t;

  exp_t sb[$];
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse pops one expected response.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 result=0x%016h, expected no pending operation", result);
      end else begin
        e = sb.pop_front();
        check64("result", result, e.res);
        check64("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
      end
    end
  end

  // Issue one operation, optionally re-pulse start mid-flight, and time done.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] er, input logic ed, input int pulse_at);
    int   edge_n;
    logic seen;
    exp_t e;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    e.res = er; e.dbz = ed;
    sb.push_back(e);
    @(posedge clk);
    edge_n = 1;
    #1;
    start = 1'b0; op = ~o; a = $urandom; b = $urandom;
    check64("busy_after_start", {63'b0, busy}, 64'd1);
    seen = 1'b0;
    while (!seen && edge_n < 60) begin
      @(posedge clk);
      edge_n++;
      #1;
      if (edge_n == pulse_at) begin
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done within %0d edges, expected done at edge 34", edge_n);
    end else begin
      check64("done_latency", 64'(edge_n), 64'd34);
      @(posedge clk);
      #1;
      check64("done_one_cycle", {62'b0, done, busy}, 64'd0);
    end
  endtask

  initial begin
    int dc0;
    clr_n = 1'b0; start = 1'b0; op = OP_MUL; a = '0; b = '0;
    #1;
    check64("reset_busy",   {63'b0, busy}, 64'd0);
    check64("reset_done",   {63'b0, done}, 64'd0);
    check64("reset_result", result, 64'd0);
    check64("reset_dbz",    {63'b0, div_by_zero}, 64'd0);
    #16;
    clr_n = 1'b1;

    run_op(OP_MUL, 32'd7,         32'hFFFFFFFD, 64'hFFFFFFFF_FFFFFFEB, 1'b0, 0);
    run_op(OP_MUL, 32'h80000000,  32'h80000000, 64'h40000000_00000000, 1'b0, 0);
    run_op(OP_DIV, 32'd17,        32'hFFFFFFFB, 64'h00000002_FFFFFFFD, 1'b0, 0);
    run_op(OP_DIV, 32'hFFFFFFEF,  32'd5,        64'hFFFFFFFE_FFFFFFFD, 1'b0, 0);
    run_op(OP_DIV, 32'd9,         32'd0,        64'h00000009_FFFFFFFF, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1;
    check64("dbz_hold",    {63'b0, div_by_zero}, 64'd1);
    check64("result_hold", result, 64'h00000009_FFFFFFFF);
    run_op(OP_MUL, 32'd3,         32'd5,        64'd15,                1'b0, 0);
    run_op(OP_DIV, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 0);
    run_op(OP_DIV, 32'hFFFFFF9C,  32'hFFFFFFF9, 64'hFFFFFFFE_0000000E, 1'b0, 0);

    dc0 = done_cnt;
    run_op(OP_MUL, 32'd123,       32'hFFFFFFD3, 64'hFFFFFFFF_FFFFEA61, 1'b0, 10);
    repeat (40) @(posedge clk);
    #1;
    check64("single_done_pulse", 64'(done_cnt - dc0), 64'd1);
    check64("result_after_ignored_start", result, 64'hFFFFFFFF_FFFFEA61);

    dc0 = done_cnt;
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    check64("midop_reset_busy",   {63'b0, busy}, 64'd0);
    check64("midop_reset_done",   {63'b0, done}, 64'd0);
    check64("midop_reset_result", result, 64'd0);
    check64("midop_reset_dbz",    {63'b0, div_by_zero}, 64'd0);
    repeat (40) @(posedge clk);
    check64("no_done_after_reset", 64'(done_cnt - dc0), 64'd0);
    @(posedge clk);
    #3;
    clr_n = 1'b1;
    run_op(OP_MUL, 32'd6,         32'd7,        64'd42,                1'b0, 0);

    repeat (2) @(posedge clk);
    check64("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; result width is 2*WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port clr_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request, sampled only in IDLE.
REQ-005 SHALL have port op  input  1  0 = signed multiply, 1 = signed divide.
REQ-006 SHALL have port a  input  WIDTH  multiplicand / dividend, two's complement.
REQ-007 SHALL have port b  input  WIDTH  multiplier / divisor, two's complement.
REQ-008 SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 SHALL have port done  output  1  one-cycle completion pulse; drives the HI/LO register load enable.
REQ-010 SHALL have port result  output  2*WIDTH  mul: product[63:0]; div: HI = remainder, LO = quotient.
REQ-011 SHALL have port div_by_zero  output  1  status of the last completed divide.

Function
REQ-012 SHALL use states IDLE, CALC, FIX and DONE.
REQ-013 SHALL in IDLE with start=1 capture a, b and op, clear the iteration counter, and go to CALC on the same edge.
REQ-014 SHALL ignore start in every state other than IDLE, with no queuing.
REQ-015 SHALL perform, per CALC cycle, one radix-2 Booth step (mul) or one restoring step on magnitudes (div), for exactly WIDTH cycles, then go to FIX.
REQ-016 SHALL in FIX apply the sign correction (div: negate quotient if operand signs differ, negate remainder if dividend negative), register result, and go to DONE.
REQ-017 SHALL hold done=1 in DONE for exactly one cycle, then return to IDLE.
REQ-018 SHALL give a latency of WIDTH+2 edges from the start-sampling edge to done high (34 when WIDTH=32).
REQ-019 SHALL allow back-to-back operation: start seen in the IDLE cycle after DONE is accepted.
REQ-020 SHALL round the divide toward zero, with remainder sign equal to dividend sign.
REQ-021 SHALL, for a divide with b=0, produce quotient all-ones and remainder = a, set div_by_zero=1, and keep the normal latency.
REQ-022 SHALL, for a divide of -2^(WIDTH-1) by -1, produce quotient 0x80000000 (wrap), remainder 0, and div_by_zero=0.
REQ-023 SHALL produce the full signed product for a multiply, including -2^31 * -2^31 = 0x4000000000000000.
REQ-024 SHALL hold result and div_by_zero stable from DONE until the next FIX; a multiply clears div_by_zero.
REQ-025 SHALL keep result, done and div_by_zero unaffected by a, b and op changing after capture.

Reset
REQ-026 SHALL, on clr_n low, immediately force state=IDLE, busy=0, done=0, result=0, div_by_zero=0 and counter=0, with no clock required.
REQ-027 SHALL, when clr_n is asserted mid-operation, abandon the operation, produce no done pulse, and leave result=0.
REQ-028 SHALL accept start on the first rising edge after clr_n deasserts.

Structure
REQ-029 SHALL place the op encoding constants, the WIDTH default and the state enumeration in a shared package, mini_src_pkg.
REQ-030 SHALL place the (WIDTH+1)-bit add/subtract datapath in one sub-module, mdu_addsub, shared by the Booth and restoring steps.
REQ-031 SHALL register all outputs, with no combinational path from inputs to outputs.

Verification
REQ-032 SHALL cover: mul, a=7, b=-3 -> done at edge 34, result=0xFFFFFFFF_FFFFFFEB.
REQ-033 SHALL cover: mul, a=b=0x80000000 -> result=0x40000000_00000000.
REQ-034 SHALL cover: div, a=17, b=-5 -> LO=0xFFFFFFFD, HI=0x00000002, div_by_zero=0; also a=-17, b=5 -> LO=0xFFFFFFFD, HI=0xFFFFFFFE.
REQ-035 SHALL cover: div, a=9, b=0 -> LO=0xFFFFFFFF, HI=0x00000009, div_by_zero=1 at edge 34.
REQ-036 SHALL cover: start pulsed again at cycle 10 of an operation -> ignored, exactly one done pulse, first result intact.
REQ-037 SHALL cover: clr_n low at cycle 20 of a divide -> busy=0 asynchronously, no done pulse, result=0; a new mul then completes normally.
